// File: rtl/alu_arb_pkg.sv
// Shared types and helpers for the round-robin ALU arbiter slice.
package alu_arb_pkg;

    // Operation lifecycle: wait for a request, let the ALU settle, hold the result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int unsigned OPW_DEFAULT = 3;

    // The ALU result carries one extra bit above the operand width.
    function automatic int unsigned res_width(input int unsigned nbits);
        return nbits + 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first requester above i_ptr, wrapping.
module rr_picker #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned PTRW = 2
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [PTRW-1:0] i_ptr,
    output logic [NREQ-1:0] o_grant,
    output logic            o_any
);

    int unsigned w_dist;
    int unsigned w_best;
    int unsigned w_sel;

    // Pick the requester at the smallest circular distance past the pointer.
    always_comb begin
        w_dist  = 0;
        w_best  = NREQ;
        w_sel   = 0;
        o_grant = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (i_req[i]) begin
                w_dist = (i + NREQ - 1 - 32'(i_ptr)) % NREQ;
                if (w_dist < w_best) begin
                    w_best = w_dist;
                    w_sel  = i;
                end
            end
        end
        for (int unsigned i = 0; i < NREQ; i++) begin
            o_grant[i] = i_req[i] && (i == w_sel);
        end
    end

    assign o_any = |i_req;

endmodule

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one combinational ALU among NREQ requesters.
module alu_rr_arbiter
    import alu_arb_pkg::*;
#(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned NBITS = 16,
    parameter int unsigned OPW   = OPW_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NREQ-1:0]               req_valid,
    output logic [NREQ-1:0]               req_ready,
    input  logic [NREQ*NBITS-1:0]         req_a,
    input  logic [NREQ*NBITS-1:0]         req_b,
    input  logic [NREQ*OPW-1:0]           req_op,
    output logic [NREQ-1:0]               rsp_valid,
    input  logic [NREQ-1:0]               rsp_ready,
    output logic [res_width(NBITS)-1:0]   rsp_y,
    output logic                          rsp_co,
    output logic [NBITS-1:0]              alu_a,
    output logic [NBITS-1:0]              alu_b,
    output logic [OPW-1:0]                alu_opcode,
    input  logic [res_width(NBITS)-1:0]   alu_y,
    input  logic                          alu_co,
    output logic                          busy
);

    localparam int unsigned PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t           r_state;
    logic [PTRW-1:0]  r_ptr;
    logic [PTRW-1:0]  r_owner;

    logic [NREQ-1:0]  w_grant;
    logic             w_any;
    logic [PTRW-1:0]  w_gidx;
    logic [NBITS-1:0] w_sel_a;
    logic [NBITS-1:0] w_sel_b;
    logic [OPW-1:0]   w_sel_op;
    logic [NREQ-1:0]  w_owner_oh;
    logic             w_owner_rdy;

    rr_picker #(
        .NREQ (NREQ),
        .PTRW (PTRW)
    ) u_picker (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_any   (w_any)
    );

    // Encode the one-hot grant and mux the granted requester's operand slices.
    always_comb begin
        w_gidx   = '0;
        w_sel_a  = '0;
        w_sel_b  = '0;
        w_sel_op = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_gidx   = PTRW'(i);
                w_sel_a  = req_a[i*NBITS +: NBITS];
                w_sel_b  = req_b[i*NBITS +: NBITS];
                w_sel_op = req_op[i*OPW +: OPW];
            end
        end
    end

    // Decode the owner index so handshakes can be masked to the owning requester.
    always_comb begin
        w_owner_oh = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            w_owner_oh[i] = (r_owner == PTRW'(i));
        end
    end

    assign w_owner_rdy = |(rsp_ready & w_owner_oh);

    // Grants are only offered in IDLE and are forced off while reset is held.
    assign req_ready = (rst_n && r_state == IDLE) ? w_grant : '0;
    assign rsp_valid = (r_state == RESP) ? w_owner_oh : '0;
    assign busy      = (r_state != IDLE);

    // Arbitration FSM: accept a request, wait one cycle for the ALU, hold the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_ptr      <= PTRW'(NREQ - 1);
            r_owner    <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= '0;
            rsp_y      <= '0;
            rsp_co     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        alu_a      <= w_sel_a;
                        alu_b      <= w_sel_b;
                        alu_opcode <= w_sel_op;
                        r_owner    <= w_gidx;
                        r_state    <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_y   <= alu_y;
                    rsp_co  <= alu_co;
                    r_state <= RESP;
                end
                RESP: begin
                    if (w_owner_rdy) begin
                        r_ptr   <= r_owner;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Self-checking bench for alu_rr_arbiter with a transaction-level reference model.
module tb_alu_rr_arbiter;

    localparam int NREQ  = 4;
    localparam int NBITS = 16;
    localparam int OPW   = 3;

    logic                  clk;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*NBITS-1:0] req_a;
    logic [NREQ*NBITS-1:0] req_b;
    logic [NREQ*OPW-1:0]   req_op;
    logic [NREQ-1:0]       rsp_valid;
    logic [NREQ-1:0]       rsp_ready;
    logic [NBITS:0]        rsp_y;
    logic                  rsp_co;
    logic [NBITS-1:0]      alu_a;
    logic [NBITS-1:0]      alu_b;
    logic [OPW-1:0]        alu_opcode;
    logic [NBITS:0]        alu_y;
    logic                  alu_co;
    logic                  busy;

    alu_rr_arbiter #(
        .NREQ  (NREQ),
        .NBITS (NBITS),
        .OPW   (OPW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_y      (rsp_y),
        .rsp_co     (rsp_co),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_opcode (alu_opcode),
        .alu_y      (alu_y),
        .alu_co     (alu_co),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bench ALU: returns {co, y}.
    function automatic logic [NBITS+1:0] alu_f(input logic [NBITS-1:0] a,
                                               input logic [NBITS-1:0] b,
                                               input logic [OPW-1:0]   op);
        logic [NBITS:0] y;
        logic           co;
        case (op)
            3'd0:    y = {1'b0, a & b};
            3'd1:    y = {1'b0, a} + {1'b0, b};
            3'd2:    y = {1'b0, a} - {1'b0, b};
            3'd3:    y = {1'b0, a | b};
            3'd4:    y = {1'b0, a ^ b};
            3'd5:    y = {1'b0, ~a};
            3'd6:    y = {1'b0, b} - {1'b0, a};
            default: y = {1'b0, a} + {1'b0, b} + (NBITS+1)'(1);
        endcase
        co = (op == 3'd1 || op == 3'd2 || op == 3'd6 || op == 3'd7) ? y[NBITS] : ^a;
        return {co, y};
    endfunction

    always_comb {alu_co, alu_y} = alu_f(alu_a, alu_b, alu_opcode);

    int n_checks = 0;
    int n_fail   = 0;

    // Per-requester operand sources driven into the packed buses each cycle.
    logic [NBITS-1:0] ta  [NREQ];
    logic [NBITS-1:0] tbv [NREQ];
    logic [OPW-1:0]   top [NREQ];

    // Reference model: last served requester, in-flight op and its age.
    int               m_last;
    int               m_owner;
    int               m_age;     // -1 idle, 0 ALU settling, >=1 responding
    logic [NBITS-1:0] m_a, m_b;
    logic [OPW-1:0]   m_op;
    logic [NBITS:0]   m_y;
    logic             m_co;

    int dut_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [NREQ-1:0] v);
        for (int k = 1; k <= NREQ; k++) begin
            if (v[(m_last + k) % NREQ]) return (m_last + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_last  = NREQ - 1;
        m_owner = 0;
        m_age   = -1;
        m_a = '0; m_b = '0; m_op = '0; m_y = '0; m_co = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        req_valid = '1;
        rsp_ready = '0;
        rst_n = 1'b0;
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'(0));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_alu_a", 64'(alu_a), 64'(0));
        chk("rst_alu_b", 64'(alu_b), 64'(0));
        chk("rst_alu_op", 64'(alu_opcode), 64'(0));
        chk("rst_rsp_y", 64'(rsp_y), 64'(0));
        chk("rst_rsp_co", 64'(rsp_co), 64'(0));
        req_valid = '0;
        model_reset();
        dut_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One cycle: drive at negedge, compare against the model, then advance the model.
    task automatic step(input logic [NREQ-1:0] v, input logic [NREQ-1:0] rr);
        int g;
        logic [NREQ-1:0] e_rr, e_rv;
        @(negedge clk);
        req_valid = v;
        rsp_ready = rr;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*NBITS +: NBITS] = ta[i];
            req_b[i*NBITS +: NBITS] = tbv[i];
            req_op[i*OPW +: OPW]    = top[i];
        end
        #1;
        g    = pick(v);
        e_rr = '0;
        e_rv = '0;
        if (m_age < 0 && g >= 0) e_rr[g] = 1'b1;
        if (m_age >= 1) e_rv[m_owner] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(e_rr));
        chk("rsp_valid", 64'(rsp_valid), 64'(e_rv));
        chk("busy", 64'(busy), 64'(m_age >= 0));
        chk("alu_a", 64'(alu_a), 64'(m_a));
        chk("alu_b", 64'(alu_b), 64'(m_b));
        chk("alu_opcode", 64'(alu_opcode), 64'(m_op));
        chk("rsp_y", 64'(rsp_y), 64'(m_y));
        chk("rsp_co", 64'(rsp_co), 64'(m_co));
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) dut_q.push_back(i);
        if (m_age < 0) begin
            if (g >= 0) begin
                m_a = ta[g]; m_b = tbv[g]; m_op = top[g];
                m_owner = g;
                m_age = 0;
            end
        end else if (m_age == 0) begin
            {m_co, m_y} = alu_f(m_a, m_b, m_op);
            m_age = 1;
        end else if (rr[m_owner]) begin
            m_last = m_owner;
            m_age  = -1;
        end else begin
            m_age++;
        end
    endtask

    task automatic chk_seq(input string name, input int exp[]);
        chk({name, "_len"}, 64'(dut_q.size()), 64'(exp.size()));
        for (int i = 0; i < exp.size() && i < dut_q.size(); i++)
            chk(name, 64'(dut_q[i]), 64'(exp[i]));
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = '0; rsp_ready = '0;
        req_a = '0; req_b = '0; req_op = '0;
        for (int i = 0; i < NREQ; i++) begin ta[i] = '0; tbv[i] = '0; top[i] = '0; end
        model_reset();
        do_reset();

        // Requester 0 alone: 10 + 5.
        ta[0] = 16'd10; tbv[0] = 16'd5; top[0] = 3'b001;
        step(4'b0001, 4'b0001);
        chk("solo_grant", 64'(req_ready), 64'(4'b0001));
        step(4'b0000, 4'b0001);
        chk("solo_alu_a", 64'(alu_a), 64'(10));
        chk("solo_alu_b", 64'(alu_b), 64'(5));
        step(4'b0000, 4'b0001);
        chk("solo_rsp_valid", 64'(rsp_valid), 64'(4'b0001));
        chk("solo_rsp_y", 64'(rsp_y), 64'(15));
        chk("solo_rsp_co", 64'(rsp_co), 64'(0));
        step(4'b0000, 4'b0000);

        // Everyone valid: strict rotation from requester 0.
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            ta[i] = 16'(100 * (i + 1)); tbv[i] = 16'(7 + i); top[i] = 3'(i + 1);
        end
        for (int c = 0; c < 18; c++) step(4'b1111, 4'b1111);
        chk_seq("rot_seq", '{0, 1, 2, 3, 0, 1});

        // Only 1 and 3 compete.
        do_reset();
        step(4'b0010, 4'b1111);
        for (int c = 0; c < 11; c++) step(4'b1010, 4'b1111);
        chk_seq("pair_seq", '{1, 3, 1, 3});

        // Requester 2 holds its response; others pend.
        do_reset();
        ta[2] = 16'd20; tbv[2] = 16'd30; top[2] = 3'b110;
        step(4'b0100, 4'b0000);
        step(4'b1111, 4'b0000);
        for (int c = 0; c < 5; c++) begin
            step(4'b1111, 4'b1011);
            chk("hold_rsp_y", 64'(rsp_y), 64'(10));
            chk("hold_rsp_co", 64'(rsp_co), 64'(0));
            chk("hold_no_ready", 64'(req_ready), 64'(0));
        end
        step(4'b0011, 4'b0100);
        step(4'b0011, 4'b0000);
        chk("after_hold_grant", 64'(req_ready), 64'(4'b0001));
        chk_seq("hold_seq", '{2, 0});
        step(4'b0000, 4'b1111);
        step(4'b0000, 4'b1111);
        step(4'b0000, 4'b1111);

        // Reset during EXEC discards the op.
        do_reset();
        step(4'b0001, 4'b1111);
        do_reset();
        step(4'b1001, 4'b1111);
        chk("abort_first_grant", 64'(req_ready), 64'(4'b0001));
        step(4'b1001, 4'b1111);
        step(4'b1001, 4'b1111);

        // Randomized traffic with occasional resets and operand churn.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    ta[i]  = 16'($urandom);
                    tbv[i] = 16'($urandom);
                    top[i] = 3'($urandom);
                end
            end
            if ($urandom_range(0, 199) == 0) do_reset();
            else step(NREQ'($urandom), NREQ'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
